// File: rtl/alu_cmd_host.sv
// alu_cmd_host: host end of the ALU command path. Packs host requests into
// {op, b, a} command words, keeps an in-order queue of locally computed
// expected results, checks each returning ALU result against the queue head
// and hands a response plus error status back to the host.
module alu_cmd_host #(
    parameter int unsigned MAX_OUT = 4,
    parameter int unsigned TIMEOUT = 64,
    parameter int unsigned CNT_W   = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic [1:0]       req_op,
    input  logic [3:0]       req_a,
    input  logic [3:0]       req_b,
    output logic             cmd_valid,
    input  logic             cmd_ready,
    output logic [9:0]       cmd_data,
    input  logic             res_valid,
    output logic             res_ready,
    input  logic [8:0]       res_data,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic [8:0]       rsp_data,
    output logic             rsp_err,
    input  logic             clr,
    output logic             timeout,
    output logic             proto_err,
    output logic [CNT_W-1:0] cmd_cnt,
    output logic [CNT_W-1:0] err_cnt
);

    localparam int unsigned PTR_W = (MAX_OUT > 1) ? $clog2(MAX_OUT) : 1;
    localparam int unsigned OUT_W = $clog2(MAX_OUT + 1);
    localparam int unsigned TMO_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {StIdle, StSend, StRej} state_e;

    state_e           state_q;
    logic [8:0]       exp_mem [MAX_OUT];
    logic [PTR_W-1:0] wr_ptr_q;
    logic [PTR_W-1:0] rd_ptr_q;
    logic [OUT_W-1:0] outstanding_q;
    logic [TMO_W-1:0] tmo_cnt_q;
    logic [TMO_W-1:0] tmo_cnt_d;

    logic       req_is_dz;
    logic       req_fire;
    logic       rej_fire;
    logic       push;
    logic       res_fire;
    logic       pop;
    logic       stray_res;
    logic       res_mismatch;
    logic       issue_err;
    logic [8:0] exp_val;
    logic [1:0] cmd_op;
    logic [3:0] cmd_a;
    logic [3:0] cmd_b;

    assign req_is_dz = (req_op == 2'd3) && (req_b == 4'd0);
    assign cmd_op    = cmd_data[9:8];
    assign cmd_b     = cmd_data[7:4];
    assign cmd_a     = cmd_data[3:0];

    // Host request acceptance: a div-by-zero is only taken when the link is fully drained
    // so its synthetic response cannot collide with a real result.
    always_comb begin
        req_ready = 1'b0;
        if (state_q == StIdle) begin
            if (req_is_dz) begin
                req_ready = (outstanding_q == '0) && !rsp_valid;
            end else begin
                req_ready = (outstanding_q < OUT_W'(MAX_OUT));
            end
        end
    end

    assign req_fire     = req_valid && req_ready;
    assign rej_fire     = req_fire && req_is_dz;
    assign push         = cmd_valid && cmd_ready;
    assign res_ready    = !rsp_valid || rsp_ready;
    assign res_fire     = res_valid && res_ready;
    assign pop          = res_fire && (outstanding_q != '0);
    assign stray_res    = res_fire && (outstanding_q == '0);
    assign res_mismatch = (res_data != exp_mem[rd_ptr_q]);
    assign issue_err    = (pop && res_mismatch) || rej_fire;

    // Expected result of the command currently on the link; div-by-zero never reaches here.
    always_comb begin
        exp_val = '0;
        case (cmd_op)
            2'd0: exp_val = {5'd0, cmd_a} + {5'd0, cmd_b};
            2'd1: exp_val = {5'd0, cmd_a} - {5'd0, cmd_b};
            2'd2: exp_val = {5'd0, cmd_a} * {5'd0, cmd_b};
            2'd3: exp_val = (cmd_b == 4'd0) ? 9'd0 : {5'd0, cmd_a / cmd_b};
        endcase
    end

    // Command FSM with registered cmd_valid/cmd_data held stable until accepted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= StIdle;
            cmd_valid <= 1'b0;
            cmd_data  <= '0;
        end else begin
            case (state_q)
                StIdle: begin
                    if (req_fire) begin
                        if (req_is_dz) begin
                            state_q <= StRej;
                        end else begin
                            cmd_data  <= {req_op, req_b, req_a};
                            cmd_valid <= 1'b1;
                            state_q   <= StSend;
                        end
                    end
                end
                StSend: begin
                    if (cmd_ready) begin
                        cmd_valid <= 1'b0;
                        state_q   <= StIdle;
                    end
                end
                StRej:   state_q <= StIdle;
                default: state_q <= StIdle;
            endcase
        end
    end

    // Expected-value storage; contents need no reset since pointers define validity.
    always_ff @(posedge clk) begin
        if (push) begin
            exp_mem[wr_ptr_q] <= exp_val;
        end
    end

    // Queue pointers and in-flight count; pointers wrap naturally at power-of-2 depth.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr_q      <= '0;
            rd_ptr_q      <= '0;
            outstanding_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
            case ({push, pop})
                2'b10:   outstanding_q <= outstanding_q + 1'b1;
                2'b01:   outstanding_q <= outstanding_q - 1'b1;
                default: outstanding_q <= outstanding_q;
            endcase
        end
    end

    // Response register toward the host: checked result or div-by-zero reject.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else if (pop) begin
            rsp_valid <= 1'b1;
            rsp_data  <= res_data;
            rsp_err   <= res_mismatch;
        end else if (rej_fire) begin
            rsp_valid <= 1'b1;
            rsp_data  <= 9'h1FF;
            rsp_err   <= 1'b1;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

    // Stall counter: runs only while results are owed and none is arriving; saturates.
    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (res_fire || (outstanding_q == '0)) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TMO_W'(TIMEOUT)) begin
            tmo_cnt_d = tmo_cnt_q + 1'b1;
        end
    end

    // Sticky status flags and saturating statistics; clr wins over a same-cycle set.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            tmo_cnt_q <= '0;
            timeout   <= 1'b0;
            proto_err <= 1'b0;
            cmd_cnt   <= '0;
            err_cnt   <= '0;
        end else begin
            tmo_cnt_q <= tmo_cnt_d;
            if (clr) begin
                timeout   <= 1'b0;
                proto_err <= 1'b0;
                cmd_cnt   <= '0;
                err_cnt   <= '0;
            end else begin
                if (tmo_cnt_d == TMO_W'(TIMEOUT)) timeout <= 1'b1;
                if (stray_res) proto_err <= 1'b1;
                if (push && (cmd_cnt != '1)) cmd_cnt <= cmd_cnt + 1'b1;
                if (issue_err && (err_cnt != '1)) err_cnt <= err_cnt + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_host.sv
// tb_alu_cmd_host: bench for alu_cmd_host. The bench plays both host and ALU;
// expected responses are queued when stimulus is driven and checked as they appear.
module tb_alu_cmd_host;

    logic        clk;
    logic        reset;
    logic        req_valid;
    logic        req_ready;
    logic [1:0]  req_op;
    logic [3:0]  req_a;
    logic [3:0]  req_b;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [9:0]  cmd_data;
    logic        res_valid;
    logic        res_ready;
    logic [8:0]  res_data;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [8:0]  rsp_data;
    logic        rsp_err;
    logic        clr;
    logic        timeout;
    logic        proto_err;
    logic [15:0] cmd_cnt;
    logic [15:0] err_cnt;

    alu_cmd_host #(
        .MAX_OUT(4),
        .TIMEOUT(64),
        .CNT_W  (16)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_op   (req_op),
        .req_a    (req_a),
        .req_b    (req_b),
        .cmd_valid(cmd_valid),
        .cmd_ready(cmd_ready),
        .cmd_data (cmd_data),
        .res_valid(res_valid),
        .res_ready(res_ready),
        .res_data (res_data),
        .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready),
        .rsp_data (rsp_data),
        .rsp_err  (rsp_err),
        .clr      (clr),
        .timeout  (timeout),
        .proto_err(proto_err),
        .cmd_cnt  (cmd_cnt),
        .err_cnt  (err_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] op;
        logic [3:0] a;
        logic [3:0] b;
        logic [8:0] ret;   // value the fake ALU sends back
        logic [8:0] exp;   // arithmetically correct result
        int         hold;  // cycles of host backpressure on the response
    } vec_t;

    typedef struct packed {
        logic [8:0] data;
        logic       err;
    } rsp_t;

    localparam int NV = 10;
    vec_t vecs [NV];
    rsp_t sb_q [$];
    int   n_checks = 0;
    int   n_errors = 0;
    int   n_sent   = 0;
    int   exp_errs = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic bound_fail(input string name);
        n_checks++;
        n_errors++;
        $display("FAIL %s: got no handshake, expected one within the cycle budget", name);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_rsp(input logic [8:0] d, input logic e);
        rsp_t r;
        r.data = d;
        r.err  = e;
        sb_q.push_back(r);
    endtask

    task automatic accept_req(input logic [1:0] op, input logic [3:0] a, input logic [3:0] b);
        logic acc;
        int   n;
        acc = 1'b0;
        n   = 0;
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        while (!acc && n < 40) begin
            @(negedge clk);
            acc = req_ready;
            n++;
            tick();
        end
        req_valid = 1'b0;
        if (!acc) bound_fail("req_accept");
    endtask

    task automatic wait_cmd(input logic [9:0] word);
        logic done;
        int   n;
        done = 1'b0;
        n    = 0;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            if (cmd_valid && cmd_ready) begin
                check("cmd_data", {22'd0, cmd_data}, {22'd0, word});
                done = 1'b1;
                n_sent++;
            end
            tick();
        end
        if (!done) bound_fail("cmd_handshake");
    endtask

    task automatic return_res(input logic [8:0] val);
        logic done;
        int   n;
        done = 1'b0;
        n    = 0;
        res_valid = 1'b1;
        res_data  = val;
        while (!done && n < 40) begin
            @(negedge clk);
            n++;
            done = res_ready;
            tick();
        end
        res_valid = 1'b0;
        if (!done) bound_fail("res_handshake");
    endtask

    // Response monitor: every host-side handshake is matched against the scoreboard.
    always @(negedge clk) begin : mon
        rsp_t e;
        if (!reset && rsp_valid && rsp_ready) begin
            if (sb_q.size() == 0) begin
                n_checks++;
                n_errors++;
                $display("FAIL unexpected_rsp: got data %0h err %0b, expected no response",
                         rsp_data, rsp_err);
            end else begin
                e = sb_q.pop_front();
                check("rsp_data", {23'd0, rsp_data}, {23'd0, e.data});
                check("rsp_err", {31'd0, rsp_err}, {31'd0, e.err});
            end
        end
    end

    initial begin
        #200us;
        $display("FAIL watchdog: got no end of test, expected $finish");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'd0, 4'd7,  4'd9,  9'h010, 9'h010, 0};
        vecs[1] = '{2'd1, 4'd2,  4'd5,  9'h1FD, 9'h1FD, 0};
        vecs[2] = '{2'd1, 4'd2,  4'd5,  9'h003, 9'h1FD, 0};
        vecs[3] = '{2'd2, 4'd15, 4'd15, 9'h0E1, 9'h0E1, 3};
        vecs[4] = '{2'd3, 4'd13, 4'd4,  9'h003, 9'h003, 0};
        vecs[5] = '{2'd0, 4'd15, 4'd15, 9'h01F, 9'h01E, 0};
        vecs[6] = '{2'd1, 4'd0,  4'd15, 9'h1F1, 9'h1F1, 0};
        vecs[7] = '{2'd3, 4'd4,  4'd9,  9'h000, 9'h000, 0};
        vecs[8] = '{2'd2, 4'd6,  4'd7,  9'h02B, 9'h02A, 2};
        vecs[9] = '{2'd3, 4'd15, 4'd1,  9'h00F, 9'h00F, 0};

        reset = 1'b1;
        req_valid = 1'b0; req_op = '0; req_a = '0; req_b = '0;
        cmd_ready = 1'b1; res_valid = 1'b0; res_data = '0;
        rsp_ready = 1'b1; clr = 1'b0;
        repeat (3) tick();

        // Reset values
        check("rst_req_ready", {31'd0, req_ready}, 32'd1);
        check("rst_res_ready", {31'd0, res_ready}, 32'd1);
        check("rst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        check("rst_cmd_data", {22'd0, cmd_data}, 32'd0);
        check("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check("rst_rsp_data", {23'd0, rsp_data}, 32'd0);
        check("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        check("rst_timeout", {31'd0, timeout}, 32'd0);
        check("rst_proto_err", {31'd0, proto_err}, 32'd0);
        check("rst_cmd_cnt", {16'd0, cmd_cnt}, 32'd0);
        check("rst_err_cnt", {16'd0, err_cnt}, 32'd0);
        reset = 1'b0;
        tick();

        // Table-driven single transactions
        for (int i = 0; i < NV; i++) begin
            expect_rsp(vecs[i].ret, vecs[i].ret != vecs[i].exp);
            if (vecs[i].ret != vecs[i].exp) exp_errs++;
            accept_req(vecs[i].op, vecs[i].a, vecs[i].b);
            wait_cmd({vecs[i].op, vecs[i].b, vecs[i].a});
            rsp_ready = (vecs[i].hold == 0);
            return_res(vecs[i].ret);
            for (int k = 0; k < vecs[i].hold; k++) begin
                @(negedge clk);
                check("hold_rsp_valid", {31'd0, rsp_valid}, 32'd1);
                check("hold_res_ready", {31'd0, res_ready}, 32'd0);
                check("hold_rsp_data", {23'd0, rsp_data}, {23'd0, vecs[i].ret});
                tick();
            end
            rsp_ready = 1'b1;
            repeat (2) tick();
            check("vec_cmd_cnt", {16'd0, cmd_cnt}, n_sent);
            check("vec_err_cnt", {16'd0, err_cnt}, exp_errs);
        end

        // Div-by-zero reject: never sent, synthetic error response
        expect_rsp(9'h1FF, 1'b1);
        exp_errs++;
        req_valid = 1'b1; req_op = 2'd3; req_a = 4'd9; req_b = 4'd0;
        @(negedge clk);
        check("dz_req_ready", {31'd0, req_ready}, 32'd1);
        tick();
        req_valid = 1'b0;
        #1;
        check("dz_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        check("dz_rsp_valid", {31'd0, rsp_valid}, 32'd1);
        check("dz_rsp_data", {23'd0, rsp_data}, 32'h1FF);
        check("dz_rsp_err", {31'd0, rsp_err}, 32'd1);
        check("rej_req_ready", {31'd0, req_ready}, 32'd0);
        repeat (2) tick();
        check("dz_no_cmd", {31'd0, cmd_valid}, 32'd0);
        check("dz_cmd_cnt", {16'd0, cmd_cnt}, n_sent);
        check("dz_err_cnt", {16'd0, err_cnt}, exp_errs);

        // Fill to MAX_OUT, check backpressure, then free one slot for the 5th
        expect_rsp(9'd2, 1'b0);
        accept_req(2'd0, 4'd1, 4'd1);
        wait_cmd(10'h011);
        req_valid = 1'b1; req_op = 2'd3; req_a = 4'd5; req_b = 4'd0;
        @(negedge clk);
        check("dz_blocked_ready", {31'd0, req_ready}, 32'd0);
        tick();
        req_valid = 1'b0;
        for (int k = 2; k <= 4; k++) begin
            expect_rsp(9'(2 * k), 1'b0);
            accept_req(2'd0, 4'(k), 4'(k));
            wait_cmd({2'd0, 4'(k), 4'(k)});
        end
        expect_rsp(9'd10, 1'b0);
        req_valid = 1'b1; req_op = 2'd0; req_a = 4'd5; req_b = 4'd5;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("full_req_ready", {31'd0, req_ready}, 32'd0);
            tick();
        end
        check("full_no_cmd", {31'd0, cmd_valid}, 32'd0);
        return_res(9'd2);
        accept_req(2'd0, 4'd5, 4'd5);
        wait_cmd(10'h055);
        return_res(9'd4);
        return_res(9'd6);
        return_res(9'd8);
        return_res(9'd10);
        repeat (2) tick();
        check("full_cmd_cnt", {16'd0, cmd_cnt}, n_sent);

        // Push and pop in the same cycle
        expect_rsp(9'd3, 1'b0);
        accept_req(2'd0, 4'd1, 4'd2);
        wait_cmd(10'h021);
        cmd_ready = 1'b0;
        expect_rsp(9'd5, 1'b0);
        accept_req(2'd0, 4'd2, 4'd3);
        cmd_ready = 1'b1; res_valid = 1'b1; res_data = 9'd3;
        @(negedge clk);
        check("both_cmd_valid", {31'd0, cmd_valid}, 32'd1);
        check("both_cmd_data", {22'd0, cmd_data}, 32'h032);
        check("both_res_ready", {31'd0, res_ready}, 32'd1);
        tick();
        res_valid = 1'b0;
        n_sent++;
        return_res(9'd5);
        repeat (2) tick();
        check("both_proto_err", {31'd0, proto_err}, 32'd0);

        // Stalled command link, then a missing result triggers the timeout
        cmd_ready = 1'b0;
        expect_rsp(9'd15, 1'b0);
        accept_req(2'd2, 4'd3, 4'd5);
        check("send_req_ready", {31'd0, req_ready}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            @(negedge clk);
            check("stall_cmd_valid", {31'd0, cmd_valid}, 32'd1);
            check("stall_cmd_data", {22'd0, cmd_data}, 32'h253);
            tick();
        end
        cmd_ready = 1'b1;
        wait_cmd(10'h253);
        repeat (20) tick();
        check("tmo_early", {31'd0, timeout}, 32'd0);
        repeat (50) tick();
        check("tmo_set", {31'd0, timeout}, 32'd1);
        return_res(9'd15);
        repeat (2) tick();
        check("tmo_sticky", {31'd0, timeout}, 32'd1);
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("tmo_clr", {31'd0, timeout}, 32'd0);
        exp_errs = 0;
        n_sent   = 0;
        check("clr1_cmd_cnt", {16'd0, cmd_cnt}, n_sent);

        // Stray result with nothing outstanding
        check("pre_proto", {31'd0, proto_err}, 32'd0);
        res_valid = 1'b1; res_data = 9'h055;
        @(negedge clk);
        check("stray_res_ready", {31'd0, res_ready}, 32'd1);
        tick();
        res_valid = 1'b0;
        check("proto_set", {31'd0, proto_err}, 32'd1);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("stray_no_rsp", {31'd0, rsp_valid}, 32'd0);
            tick();
        end
        clr = 1'b1;
        tick();
        clr = 1'b0;
        check("proto_clr", {31'd0, proto_err}, 32'd0);
        check("clr_err_cnt", {16'd0, err_cnt}, 32'd0);

        // Reset in the middle of traffic forgets everything in flight
        accept_req(2'd1, 4'd9, 4'd3);
        wait_cmd(10'h139);
        cmd_ready = 1'b0;
        accept_req(2'd0, 4'd4, 4'd4);
        @(negedge clk);
        check("mid_cmd_valid", {31'd0, cmd_valid}, 32'd1);
        check("mid_cmd_cnt", {16'd0, cmd_cnt}, n_sent);
        #2 reset = 1'b1;
        #1;
        check("arst_cmd_valid", {31'd0, cmd_valid}, 32'd0);
        check("arst_req_ready", {31'd0, req_ready}, 32'd1);
        check("arst_cmd_cnt", {16'd0, cmd_cnt}, 32'd0);
        tick();
        reset = 1'b0;
        cmd_ready = 1'b1;
        tick();
        res_valid = 1'b1; res_data = 9'h006;
        tick();
        res_valid = 1'b0;
        check("arst_forgot", {31'd0, proto_err}, 32'd1);
        repeat (2) tick();

        check("sb_empty", sb_q.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
